snake_body_scanner: RTL

- Reader side of the snake body circular buffer that the length/position updater writes. Each entry holds one body segment's {X,Y}.
- On request, walks the buffer from tail pointer to head pointer, one entry per cycle.
- Builds a 256-bit occupancy map of the grid, for use by the apple generator and the display path.
- Answers registered "is this cell occupied" queries for body-collision checks.
- The map is double-buffered: a published map stays stable while the next scan is in progress.

---
 rtl/snake_pkg.sv | 27 ++
 rtl/snake_ptr_wrap.sv | 32 +++
 rtl/snake_body_scanner.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/snake_pkg.sv
// Shared definitions for the snake body buffer: geometry, the empty-slot code,
// the scanner state encoding, and the cell-index mapping that the writer, the
// apple generator and the scanner all use.
package snake_pkg;

    localparam int PTR_W  = 8;    // buffer pointer / address width
    localparam int GRID_W = 4;    // width of one grid coordinate
    localparam int DEPTH  = 225;  // 15x15 playfield, one entry per segment
    localparam int CELLS  = 256;  // occupancy map size (16x16 index space)

    localparam logic [7:0]       EMPTY_CODE = 8'hFF;
    localparam logic [PTR_W-1:0] DEPTH_P    = PTR_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_IDX   = PTR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WALK   = 2'd1,
        ST_COMMIT = 2'd2
    } state_e;

    // Occupancy bit for cell (x, y) is x*16 + y; the concatenation is exactly that.
    function automatic logic [7:0] cell_index(input logic [GRID_W-1:0] x,
                                              input logic [GRID_W-1:0] y);
        return {x, y};
    endfunction

endpackage

// File: rtl/snake_ptr_wrap.sv
// Mod-DEPTH pointer helper shared by the body writer and the scanner.
//   ptr_i      : pointer to advance
//   ptr_next_o : ptr_i + 1, wrapping DEPTH-1 -> 0
//   head_i     : head pointer (must be < DEPTH)
//   tail_i     : tail pointer (must be < DEPTH)
//   dist_o     : number of entries from tail to head inclusive,
//                ((head - tail) mod DEPTH) + 1, so head == tail gives 1
module snake_ptr_wrap
    import snake_pkg::*;
(
    input  logic [PTR_W-1:0] ptr_i,
    input  logic [PTR_W-1:0] head_i,
    input  logic [PTR_W-1:0] tail_i,
    output logic [PTR_W-1:0] ptr_next_o,
    output logic [PTR_W-1:0] dist_o
);

    logic [PTR_W-1:0] span;

    always_comb begin
        ptr_next_o = (ptr_i == LAST_IDX) ? '0 : ptr_i + 1'b1;
        // The 8-bit wraparound of head - tail is corrected by adding DEPTH;
        // the true result is always below DEPTH, so it fits.
        if (head_i >= tail_i) begin
            span = head_i - tail_i;
        end else begin
            span = head_i - tail_i + DEPTH_P;
        end
        dist_o = span + 1'b1;
    end

endmodule

// File: rtl/snake_body_scanner.sv
// Reader side of the snake body circular buffer. On Start it walks the buffer
// from tail to head, one address per cycle, builds a shadow occupancy map and
// publishes it atomically, so consumers always see a complete map.
//   Clk, Reset      : clock, asynchronous active-high reset
//   Start           : scan request, honoured only in IDLE
//   Head_Ptr/Tail_Ptr : pointers sampled with Start
//   Rd_Addr/Rd_Data : buffer read port, data valid one cycle after address
//   Busy, Done      : scan in progress / one-cycle publish pulse
//   Err             : sticky out-of-range pointer flag
//   Cell_Snake_Map  : published occupancy, bit x*16+y
//   Seg_Count       : non-empty entries in the published scan
//   Query_X/Query_Y/Hit : registered lookup into the published map
module snake_body_scanner
    import snake_pkg::*;
(
    input  logic               Clk,
    input  logic               Reset,
    input  logic               Start,
    input  logic [PTR_W-1:0]   Head_Ptr,
    input  logic [PTR_W-1:0]   Tail_Ptr,
    output logic [PTR_W-1:0]   Rd_Addr,
    input  logic [7:0]         Rd_Data,
    output logic               Busy,
    output logic               Done,
    output logic               Err,
    output logic [CELLS-1:0]   Cell_Snake_Map,
    output logic [PTR_W-1:0]   Seg_Count,
    input  logic [GRID_W-1:0]  Query_X,
    input  logic [GRID_W-1:0]  Query_Y,
    output logic               Hit
);

    state_e           state_q, state_d;
    logic [PTR_W-1:0] rd_addr_q, rd_addr_d;
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] rem_q, rem_d;        // entries still to consume
    logic             live_q, live_d;      // Rd_Addr holds an issued address
    logic             dv_q, dv_d;          // Rd_Data is valid this cycle
    logic [CELLS-1:0] shadow_q, shadow_d;
    logic [PTR_W-1:0] shadow_cnt_q, shadow_cnt_d;
    logic [CELLS-1:0] map_q, map_d;
    logic [PTR_W-1:0] seg_q, seg_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             hit_q, hit_d;

    logic [PTR_W-1:0] addr_next;
    logic [PTR_W-1:0] scan_len;
    logic             ptr_bad;

    snake_ptr_wrap u_ptr_wrap (
        .ptr_i      (rd_addr_q),
        .head_i     (Head_Ptr),
        .tail_i     (Tail_Ptr),
        .ptr_next_o (addr_next),
        .dist_o     (scan_len)
    );

    assign ptr_bad = (Head_Ptr > LAST_IDX) || (Tail_Ptr > LAST_IDX);

    always_comb begin
        // NOTE: every next-state signal takes its hold value first, so no path
        // through the case below can leave one unassigned and infer a latch.
        state_d      = state_q;
        rd_addr_d    = rd_addr_q;
        head_d       = head_q;
        rem_d        = rem_q;
        live_d       = live_q;
        dv_d         = dv_q;
        shadow_d     = shadow_q;
        shadow_cnt_d = shadow_cnt_q;
        map_d        = map_q;
        seg_d        = seg_q;
        busy_d       = busy_q;
        err_d        = err_q;
        done_d       = 1'b0;
        // Lookup always uses the published map, never the shadow.
        hit_d        = map_q[cell_index(Query_X, Query_Y)];

        unique case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    if (ptr_bad) begin
                        err_d = 1'b1;
                    end else begin
                        err_d        = 1'b0;
                        head_d       = Head_Ptr;
                        rd_addr_d    = Tail_Ptr;
                        rem_d        = scan_len;
                        live_d       = 1'b1;
                        dv_d         = 1'b0;
                        shadow_d     = '0;
                        shadow_cnt_d = '0;
                        busy_d       = 1'b1;
                        state_d      = ST_WALK;
                    end
                end
            end

            ST_WALK: begin
                // Issue side: keep stepping until the head address has gone out.
                dv_d = live_q;
                if (live_q) begin
                    if (rd_addr_q != head_q) begin
                        rd_addr_d = addr_next;
                    end else begin
                        live_d = 1'b0;
                    end
                end
                // Consume side: data for the address issued one cycle earlier.
                if (dv_q) begin
                    rem_d = rem_q - 1'b1;
                    if (Rd_Data != EMPTY_CODE) begin
                        shadow_d[cell_index(Rd_Data[7:4], Rd_Data[3:0])] = 1'b1;
                        shadow_cnt_d = shadow_cnt_q + 1'b1;
                    end
                    if (rem_q == PTR_W'(1)) begin
                        state_d = ST_COMMIT;
                    end
                end
            end

            ST_COMMIT: begin
                map_d   = shadow_q;
                seg_d   = shadow_cnt_q;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: the 256-bit maps are plain flops, not a RAM, so they can and must be
    // cleared by reset; an aborted scan leaves an all-empty published map.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q      <= ST_IDLE;
            rd_addr_q    <= '0;
            head_q       <= '0;
            rem_q        <= '0;
            live_q       <= 1'b0;
            dv_q         <= 1'b0;
            shadow_q     <= '0;
            shadow_cnt_q <= '0;
            map_q        <= '0;
            seg_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            hit_q        <= 1'b0;
        end else begin
            // NOTE: non-blocking updates keep every register sampling the
            // pre-edge values, independent of statement order.
            state_q      <= state_d;
            rd_addr_q    <= rd_addr_d;
            head_q       <= head_d;
            rem_q        <= rem_d;
            live_q       <= live_d;
            dv_q         <= dv_d;
            shadow_q     <= shadow_d;
            shadow_cnt_q <= shadow_cnt_d;
            map_q        <= map_d;
            seg_q        <= seg_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
            hit_q        <= hit_d;
        end
    end

    assign Rd_Addr        = rd_addr_q;
    assign Busy           = busy_q;
    assign Done           = done_q;
    assign Err            = err_q;
    assign Cell_Snake_Map = map_q;
    assign Seg_Count      = seg_q;
    assign Hit            = hit_q;

endmodule
